morningjava_sqrt_arb: RTL
=========================

MORNINGJAVA_SQRT_ARB -- requirements
Module: morningjava_sqrt_arb

Interface
REQ-001 SHALL have parameter G_WIDTH, default 8, operand width, even, >=4.
REQ-002 SHALL have parameter G_REQ, default 4, number of requesters, 2..8.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port hold  input  1  when high, no new operand is accepted.
REQ-006 SHALL have port req_valid  input  G_REQ  per-requester operand valid.
REQ-007 SHALL have port req_data  input  G_REQ*G_WIDTH  operands, requester i at bits [i*G_WIDTH +: G_WIDTH].
REQ-008 SHALL have port req_ready  output  G_REQ  one-hot grant; handshake = req_valid[i] & req_ready[i].
REQ-009 SHALL have port res_valid  output  1  result strobe.
REQ-010 SHALL have port res_id  output  clog2(G_REQ)  index of requester owning res_data.
REQ-011 SHALL have port res_data  output  G_WIDTH/2  floor(sqrt(operand)).
REQ-012 SHALL have port busy  output  1  high while any accepted operand has no result yet.

Function
REQ-013 SHALL assert at most one req_ready bit per cycle; req_ready is combinational from req_valid, hold and the round-robin pointer.
REQ-014 SHALL grant, when hold=0 and any req_valid set, the first valid requester at or after pointer ptr, wrapping G_REQ-1 -> 0.
REQ-015 SHALL, on each handshake at requester g, load ptr <= (g+1) mod G_REQ; ptr SHALL hold otherwise.
REQ-016 SHALL drive req_ready all-zero while hold=1; hold does not affect operands already in flight.
REQ-017 SHALL register the granted operand and a valid/id tag on the accepting edge, and feed that register to the square-root pipeline each cycle.
REQ-018 SHALL carry valid and id through a shift register of exactly the pipeline depth, aligned with the data.
REQ-019 SHALL assert res_valid for one cycle per handshake, exactly G_WIDTH/2+1 rising edges after the accepting edge, with matching res_id and res_data.
REQ-020 SHALL sustain one accept per cycle; results return in acceptance order, no backpressure on results.
REQ-021 SHALL drive res_id and res_data to zero when res_valid=0.
REQ-022 SHALL compute busy as OR of the operand-register valid and all tag-stage valids.
REQ-023 SHALL treat a requester dropping req_valid without handshake as no request; no state changes.

Reset
REQ-024 SHALL, while rst=1, clear ptr to 0, all tag valids to 0, operand register to 0; outputs res_valid=0, res_id=0, res_data=0, busy=0, req_ready=0.
REQ-025 SHALL discard every in-flight operand on reset mid-operation; no res_valid after rst deasserts until a new handshake completes its latency.

Configuration
REQ-026 SHALL, with macro MORNINGJAVA_SQRT_ARB_CNT_EN defined, add output issue_cnt (16 bits) counting handshakes, wrapping 0xFFFF -> 0, cleared by rst.
REQ-027 SHALL, without MORNINGJAVA_SQRT_ARB_CNT_EN, omit issue_cnt port and counter entirely; all other behaviour identical.

Structure
REQ-028 SHALL place in package morningjava_sqrt_arb_pkg: default G_WIDTH/G_REQ constants, latency function G_WIDTH/2+1, id-width function clog2(G_REQ).
REQ-029 SHALL instantiate the team's existing pipelined square-root core morningjava_sqrt (G_WIDTH) as sole sub-module; round-robin grant logic stays inline.

Verification (G_WIDTH=8, G_REQ=4, latency 5)
REQ-030 SHALL cover: single request req0=144, hold=0 -> req_ready[0] same cycle, res_valid 5 edges later, res_id=0, res_data=12, busy high 5 cycles.
REQ-031 SHALL cover: all four valid continuously, operands 0,1,255,200 -> grants 0,1,2,3,0... one per cycle; results 0,1,15,14 back-to-back with ids 0,1,2,3.
REQ-032 SHALL cover: ptr=3 after grant to 2, only req0 and req3 valid -> req3 granted first, then req0 (wrap-around).
REQ-033 SHALL cover: hold=1 with req1 valid for 10 cycles -> req_ready=0, no res_valid; hold=0 -> grant req1 next cycle.
REQ-034 SHALL cover: rst pulsed 2 cycles after three accepts -> res_valid never asserts for them, busy=0, ptr=0, next request granted normally.
REQ-035 SHALL cover, with MORNINGJAVA_SQRT_ARB_CNT_EN: 65537 handshakes -> issue_cnt=1; without macro, port absent and REQ-030..034 pass unchanged.

Source files
------------

// File: rtl/morningjava_sqrt_arb_pkg.sv
// rtl/morningjava_sqrt_arb_pkg.sv - shared defaults and sizing helpers for the sqrt arbiter
package morningjava_sqrt_arb_pkg;

  localparam int C_WIDTH_DEF = 8;
  localparam int C_REQ_DEF   = 4;

  // Edges from the accepting edge to the result strobe
  function automatic int sqrt_latency(input int width);
    return width / 2 + 1;
  endfunction

  // Width of a requester index
  function automatic int id_width(input int nreq);
    return $clog2(nreq);
  endfunction

endpackage

// File: rtl/morningjava_sqrt.sv
// rtl/morningjava_sqrt.sv - pipelined integer square root, one root bit per registered stage
module morningjava_sqrt
  import morningjava_sqrt_arb_pkg::*;
#(
  parameter int G_WIDTH = C_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [G_WIDTH-1:0]     din,
  output logic [G_WIDTH/2-1:0]   root
);

  localparam int N  = G_WIDTH / 2;
  localparam int RW = N + 2;

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [G_WIDTH-1:0] x_in;
    logic [G_WIDTH-1:0] x_q;
    logic [RW-1:0]      rem_in;
    logic [RW-1:0]      rem_sh;
    logic [RW-1:0]      trial;
    logic [RW-1:0]      rem_q;
    logic [N-1:0]       root_in;
    logic [N-1:0]       root_q;
    logic               ge;
    logic               unused_hi;

    if (s == 0) begin : g_head
      assign x_in    = din;
      assign rem_in  = '0;
      assign root_in = '0;
    end else begin : g_link
      assign x_in    = g_stage[s-1].x_q;
      assign rem_in  = g_stage[s-1].rem_q;
      assign root_in = g_stage[s-1].root_q;
    end

    // Remainder never exceeds 2*root, so its top two bits and the root MSB are zero here
    assign rem_sh    = {rem_in[RW-3:0], x_in[G_WIDTH-1 -: 2]};
    assign trial     = {root_in, 2'b01};
    assign ge        = (rem_sh >= trial);
    assign unused_hi = ^{rem_in[RW-1:RW-2], root_in[N-1]};

    // Restoring step: accept the trial bit when the remainder covers it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q    <= '0;
        rem_q  <= '0;
        root_q <= '0;
      end else begin
        x_q    <= {x_in[G_WIDTH-3:0], 2'b00};
        rem_q  <= ge ? (rem_sh - trial) : rem_sh;
        root_q <= {root_in[N-2:0], ge};
      end
    end
  end

  assign root = g_stage[N-1].root_q;

  logic unused_tail;
  assign unused_tail = ^{g_stage[N-1].x_q, g_stage[N-1].rem_q};

endmodule

// File: rtl/morningjava_sqrt_arb.sv
// rtl/morningjava_sqrt_arb.sv - round-robin arbiter feeding a pipelined sqrt; MORNINGJAVA_SQRT_ARB_CNT_EN adds issue_cnt
module morningjava_sqrt_arb
  import morningjava_sqrt_arb_pkg::*;
#(
  parameter int G_WIDTH = C_WIDTH_DEF,
  parameter int G_REQ   = C_REQ_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hold,
  input  logic [G_REQ-1:0]             req_valid,
  input  logic [G_REQ*G_WIDTH-1:0]     req_data,
  output logic [G_REQ-1:0]             req_ready,
  output logic                         res_valid,
  output logic [id_width(G_REQ)-1:0]   res_id,
  output logic [G_WIDTH/2-1:0]         res_data,
  output logic                         busy
`ifdef MORNINGJAVA_SQRT_ARB_CNT_EN
  ,
  output logic [15:0]                  issue_cnt
`endif
);

  localparam int IDW   = id_width(G_REQ);
  localparam int DEPTH = sqrt_latency(G_WIDTH) - 1;

  logic [IDW-1:0]            ptr;
  logic [IDW-1:0]            grant_idx;
  logic                      accept;
  logic                      op_valid;
  logic [IDW-1:0]            op_id;
  logic [G_WIDTH-1:0]        op_data;
  logic [DEPTH-1:0]          tag_valid;
  logic [DEPTH-1:0][IDW-1:0] tag_id;
  logic [G_WIDTH/2-1:0]      root;

  // Pick the first valid requester at or after ptr, wrapping; nothing while held or in reset
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < G_REQ; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= G_REQ) idx = idx - G_REQ;
      if (!hold && !rst && !accept && req_valid[idx]) begin
        accept    = 1'b1;
        grant_idx = idx[IDW-1:0];
      end
    end
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Capture the granted operand with its tag and advance the round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      op_valid <= 1'b0;
      op_id    <= '0;
      op_data  <= '0;
    end else begin
      op_valid <= accept;
      if (accept) begin
        op_id   <= grant_idx;
        op_data <= req_data[grant_idx*G_WIDTH +: G_WIDTH];
        ptr     <= (grant_idx == IDW'(G_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  morningjava_sqrt #(
    .G_WIDTH (G_WIDTH)
  ) u_sqrt (
    .clk  (clk),
    .rst  (rst),
    .din  (op_data),
    .root (root)
  );

  // Valid/id tags ride alongside the sqrt stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[DEPTH-2:0], op_valid};
      tag_id    <= {tag_id[DEPTH-2:0], op_id};
    end
  end

  // Registered result, zeroed whenever there is no strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= tag_valid[DEPTH-1];
      res_id    <= tag_valid[DEPTH-1] ? tag_id[DEPTH-1] : '0;
      res_data  <= tag_valid[DEPTH-1] ? root : '0;
    end
  end

  assign busy = op_valid | (|tag_valid);

`ifdef MORNINGJAVA_SQRT_ARB_CNT_EN
  // Count handshakes, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) issue_cnt <= '0;
    else if (accept) issue_cnt <= issue_cnt + 16'd1;
  end
`endif

endmodule
